// File: rtl/criterion_if.sv
// Stream bundle between criterion and its surroundings: result/target in, activation/error out.
// master is the criterion side, slave is the associate/target/training side.
interface criterion_if #(
  parameter int RESW = 16,
  parameter int ERRW = 16,
  parameter int CNTW = 16
);
  logic            en;
  logic [RESW-1:0] res_data;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] tgt_data;
  logic            tgt_valid;
  logic            tgt_ready;
  logic [RESW-1:0] act_data;
  logic            act_valid;
  logic            act_ready;
  logic [ERRW-1:0] err_data;
  logic            err_valid;
  logic            err_ready;
  logic [CNTW-1:0] miss;

  modport master (
    input  en,
    input  res_data, res_valid, output res_ready,
    input  tgt_data, tgt_valid, output tgt_ready,
    output act_data, act_valid, input  act_ready,
    output err_data, err_valid, input  err_ready,
    output miss
  );

  modport slave (
    output en,
    output res_data, res_valid, input  res_ready,
    output tgt_data, tgt_valid, input  tgt_ready,
    input  act_data, act_valid, output act_ready,
    input  err_data, err_valid, output err_ready,
    input  miss
  );
endinterface

// File: rtl/criterion.sv
// Step activation and saturated training error for one associate result per target sample.
// CRITERION_MISS_EN: when defined, adds the saturating count of non-zero errors on miss.
module criterion #(
  parameter int              RESW = 16,
  parameter int              ERRW = 16,
  parameter logic [RESW-1:0] HIGH = 16'h00ff,
  parameter int              CNTW = 16
) (
  input logic         clk,
  input logic         rst,
  criterion_if.master bus
);
  typedef enum logic {ACCEPT, EMIT} state_t;

  localparam int DW = RESW + 1;

  state_t state_reg, state_next;

  // live_reg holds the readies low until the first edge after reset release
  logic            live_reg;
  logic            res_have_reg, tgt_have_reg;
  logic            res_neg_reg;
  logic [RESW-1:0] tgt_reg;
  logic            train_reg;
  logic            act_done_reg, err_done_reg;
  logic [RESW-1:0] act_data_reg;
  logic [ERRW-1:0] err_data_reg;

  logic            res_ready, tgt_ready, act_valid, err_valid;
  logic            res_fire, tgt_fire, act_fire, err_fire;
  logic            res_neg_now;
  logic [RESW-1:0] tgt_now;
  logic            capture, emit_done;
  logic [RESW-1:0] act_next;
  logic signed [DW-1:0] diff;
  logic [ERRW-1:0] err_next;

  assign res_fire    = bus.res_valid & res_ready;
  assign tgt_fire    = bus.tgt_valid & tgt_ready;
  assign act_fire    = act_valid & bus.act_ready;
  assign err_fire    = err_valid & bus.err_ready;

  assign res_neg_now = res_fire ? bus.res_data[RESW-1] : res_neg_reg;
  assign tgt_now     = tgt_fire ? bus.tgt_data : tgt_reg;
  assign capture     = (state_reg == ACCEPT) & (res_have_reg | res_fire) & (tgt_have_reg | tgt_fire);
  assign emit_done   = (state_reg == EMIT) & (act_done_reg | act_fire)
                     & (err_done_reg | err_fire | ~train_reg);

  assign act_next    = res_neg_now ? '0 : HIGH;
  assign diff        = {tgt_now[RESW-1], tgt_now} - {act_next[RESW-1], act_next};

  generate
    if (ERRW >= DW) begin : g_wide
      assign err_next = ERRW'(diff);
    end else begin : g_sat
      // overflow when the bits above the ERRW sign position disagree with it
      logic ovf;
      assign ovf      = ~(&diff[DW-1:ERRW-1]) & (|diff[DW-1:ERRW-1]);
      assign err_next = ovf ? (diff[DW-1] ? {1'b1, {(ERRW-1){1'b0}}} : {1'b0, {(ERRW-1){1'b1}}})
                            : diff[ERRW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ACCEPT;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCEPT: if (capture)   state_next = EMIT;
      EMIT:   if (emit_done) state_next = ACCEPT;
      default:               state_next = ACCEPT;
    endcase
  end

  always_comb begin
    res_ready = 1'b0;
    tgt_ready = 1'b0;
    act_valid = 1'b0;
    err_valid = 1'b0;
    case (state_reg)
      ACCEPT: begin
        res_ready = live_reg & ~res_have_reg;
        tgt_ready = live_reg & ~tgt_have_reg;
      end
      EMIT: begin
        act_valid = ~act_done_reg;
        err_valid = train_reg & ~err_done_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_reg     <= 1'b0;
      res_have_reg <= 1'b0;
      tgt_have_reg <= 1'b0;
      res_neg_reg  <= 1'b0;
      tgt_reg      <= '0;
      train_reg    <= 1'b0;
      act_done_reg <= 1'b0;
      err_done_reg <= 1'b0;
      act_data_reg <= '0;
      err_data_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      if (state_reg == ACCEPT) begin
        if (res_fire) begin
          res_have_reg <= 1'b1;
          res_neg_reg  <= bus.res_data[RESW-1];
        end
        if (tgt_fire) begin
          tgt_have_reg <= 1'b1;
          tgt_reg      <= bus.tgt_data;
        end
        if (capture) begin
          act_data_reg <= act_next;
          err_data_reg <= err_next;
          train_reg    <= bus.en;
          act_done_reg <= 1'b0;
          err_done_reg <= 1'b0;
        end
      end else begin
        if (act_fire) act_done_reg <= 1'b1;
        if (err_fire) err_done_reg <= 1'b1;
        if (emit_done) begin
          res_have_reg <= 1'b0;
          tgt_have_reg <= 1'b0;
        end
      end
    end
  end

  assign bus.res_ready = res_ready;
  assign bus.tgt_ready = tgt_ready;
  assign bus.act_valid = act_valid;
  assign bus.err_valid = err_valid;
  assign bus.act_data  = act_data_reg;
  assign bus.err_data  = err_data_reg;

`ifdef CRITERION_MISS_EN
  logic [CNTW-1:0] miss_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_reg <= '0;
    else if (capture && (err_next != '0) && !(&miss_reg)) miss_reg <= miss_reg + CNTW'(1);
  end

  assign bus.miss = miss_reg;
`else
  assign bus.miss = '0;
`endif
endmodule
